// File: rtl/count_monitor_pkg.sv
// rtl/count_monitor_pkg.sv - shared state type and default parameters for count_monitor
package count_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_LOCK_N = 2;
  localparam int DEF_ERRW   = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at its all-ones value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MAX_COUNT)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - locks onto an up/down counter's sequence and flags breaks and wraps
// Optional sticky error output is enabled by defining COUNT_MONITOR_STICKY_EN.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int ERRW   = DEF_ERRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] y,
  input  logic             updown,
  input  logic             cnt_rst,
  output logic             locked,
  output logic             err,
  output logic             wrap,
`ifdef COUNT_MONITOR_STICKY_EN
  output logic             err_sticky,
`endif
  output logic [ERRW-1:0]  err_count
);

  localparam logic [WIDTH-1:0] MAX_Y    = '1;
  localparam logic [3:0]       LOCK_N_W = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [WIDTH-1:0] prev_y_q, prev_y_d;
  logic             prev_up_q, prev_up_d;
  logic             prev_rst_q, prev_rst_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] exp_y;
  logic             hit;
  logic             is_wrap;
  logic [3:0]       match_inc;

  // Expected value derives only from the previous sample, never from the current one.
  always_comb begin
    if (prev_rst_q) begin
      exp_y = '0;
    end else if (prev_up_q) begin
      exp_y = prev_y_q + WIDTH'(1);
    end else begin
      exp_y = prev_y_q - WIDTH'(1);
    end
  end

  assign hit       = (y == exp_y);
  assign match_inc = match_q + 4'd1;
  assign is_wrap   = !prev_rst_q &&
                     (prev_up_q ? ((prev_y_q == MAX_Y) && (y == '0))
                                : ((prev_y_q == '0) && (y == MAX_Y)));

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    prev_y_d   = prev_y_q;
    prev_up_d  = prev_up_q;
    prev_rst_d = prev_rst_q;
    err_d      = 1'b0;
    wrap_d     = 1'b0;
    if (en) begin
      prev_y_d   = y;
      prev_up_d  = updown;
      prev_rst_d = cnt_rst;
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          match_d = '0;
        end
        ACQ: begin
          if (!hit) begin
            match_d = '0;
          end else if (match_inc >= LOCK_N_W) begin
            state_d = LOCK;
            match_d = '0;
          end else begin
            match_d = match_inc;
          end
        end
        LOCK: begin
          if (hit) begin
            wrap_d = is_wrap;
          end else begin
            err_d   = 1'b1;
            state_d = ACQ;
            match_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          match_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      match_q    <= '0;
      prev_y_q   <= '0;
      prev_up_q  <= 1'b0;
      prev_rst_q <= 1'b0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      prev_y_q   <= prev_y_d;
      prev_up_q  <= prev_up_d;
      prev_rst_q <= prev_rst_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
    end
  end

  assign locked = (state_q == LOCK);
  assign err    = err_q;
  assign wrap   = wrap_q;

  // Counts on the same edge that raises err, so err_count already reflects the pulse.
  sat_counter #(
    .W(ERRW)
  ) u_err_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_d),
    .count(err_count)
  );

`ifdef COUNT_MONITOR_STICKY_EN
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    err_sticky_d = err_sticky_q | err_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 3, bit width of the observed count.
REQ-002 Parameter LOCK_N, default 2, consecutive correct steps needed to lock (range 1..15).
REQ-003 Parameter ERRW, default 8, width of the error counter.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  sample strobe; y, updown and cnt_rst are sampled only when en=1.
REQ-007 y  in  WIDTH  observed counter value.
REQ-008 updown  in  1  counter direction, 1=up, 0=down.
REQ-009 cnt_rst  in  1  the observed counter's own active-high reset.
REQ-010 locked  out  1  high while the monitor is in LOCK.
REQ-011 err  out  1  one-cycle pulse on a sequence mismatch while in LOCK.
REQ-012 wrap  out  1  one-cycle pulse on a correct wrap-around step while in LOCK.
REQ-013 err_count  out  ERRW  saturating count of err pulses.

Function
REQ-014 The block SHALL store prev_y, prev_updown and prev_cnt_rst from the most recent en=1 sample.
REQ-015 exp SHALL be 0 when prev_cnt_rst=1, otherwise (prev_y + 1) mod 2^WIDTH when prev_updown=1, else (prev_y - 1) mod 2^WIDTH.
REQ-016 The FSM SHALL have the states IDLE, ACQ and LOCK.
REQ-017 IDLE: the first en sample captures prev_* and moves to ACQ with match_cnt=0; no compare is made.
REQ-018 ACQ: y==exp increments match_cnt; on reaching LOCK_N it moves to LOCK. y!=exp clears match_cnt and stays in ACQ, with no err.
REQ-019 LOCK: y==exp stays in LOCK. y!=exp pulses err, increments err_count, and moves to ACQ with match_cnt=0.
REQ-020 Every en sample SHALL update prev_*, including samples that mismatch.
REQ-021 wrap SHALL pulse in LOCK on a correct step MAX->0 (up) or 0->MAX (down), where MAX=2^WIDTH-1; steps caused by cnt_rst SHALL NOT pulse wrap.
REQ-022 err, wrap and locked SHALL be registered and valid the cycle after the deciding clk edge (latency 1).
REQ-023 When en=0, state, prev_* and counters SHALL hold; err and wrap SHALL be 0.
REQ-024 err_count SHALL saturate at 2^ERRW-1 and never wrap.
REQ-025 A sample with cnt_rst=1 SHALL still be compared normally; only the following sample expects 0.

Reset
REQ-026 With rst=0 at a clk edge: state=IDLE, match_cnt=0, prev_*=0, locked=0, err=0, wrap=0, err_count=0.
REQ-027 Reset SHALL take priority over en, including when asserted mid-acquisition or while in LOCK.

Configuration
REQ-028 Macro COUNT_MONITOR_STICKY_EN defined: add output err_sticky (1 bit), set with err and cleared only by rst.
REQ-029 Macro COUNT_MONITOR_STICKY_EN undefined: the err_sticky port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package count_monitor_pkg SHALL hold the state enum (IDLE, ACQ, LOCK) and the default constants for WIDTH, LOCK_N and ERRW.
REQ-031 One sub-module, sat_counter (parameterized width, inc, sat-at-max), SHALL implement err_count; the FSM and compare logic stay in count_monitor.

Verification (WIDTH=3, LOCK_N=2, en=1 unless stated)
REQ-032 Up-count y=0,1,2,3 -> locked=1 the cycle after y=2 is sampled; err=0 throughout.
REQ-033 Locked, up, y=6,7,0 -> wrap=1 for exactly one cycle after 0 is sampled; err=0.
REQ-034 Locked, up, y=3,5 -> err=1 for one cycle, err_count=1, locked=0; then y=6,7 -> locked=1 again.
REQ-035 Locked at y=4, cnt_rst=1 on that sample, next y=0 -> no err, no wrap, locked stays 1.
REQ-036 Locked, direction flip: updown=0 sampled with y=4, next y=3 -> no err; a next y=5 instead -> err=1.
REQ-037 rst=0 for one edge while locked with err_count=3 -> next cycle locked=0, err_count=0; with COUNT_MONITOR_STICKY_EN defined, err_sticky=0.
